// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit serializer between NUM_REQ requesters.
// Issues registered one-cycle load pulses and blocks new loads until the word plus GAP has drained.
module serializer_scheduler #(
   parameter int unsigned WIDTH   = 10,
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned GAP     = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       ser_load,
   output logic [WIDTH-1:0]           ser_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic [CNT_W-1:0]           words_sent
);

   localparam int unsigned ID_W      = $clog2(NUM_REQ);
   localparam int unsigned SHIFT_CYC = WIDTH - 1 + GAP;
   localparam int unsigned SC_W      = (SHIFT_CYC > 1) ? $clog2(SHIFT_CYC) : 1;
   localparam logic [SC_W-1:0] CNT_LAST = SC_W'(SHIFT_CYC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

   state_e            state_q, state_d;
   logic [SC_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   winner;
   logic              found;
   logic              window;
   logic              accept;
   logic [WIDTH-1:0]  data_sel;
   int unsigned       arb_idx;

   logic              ser_load_q;
   logic [WIDTH-1:0]  ser_data_q;
   logic [ID_W-1:0]   grant_q;
   logic              busy_q;
   logic [CNT_W-1:0]  words_q;

   // Search upward from ptr with wrap; first valid requester wins.
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      arb_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[ID_W'(arb_idx)]) begin
            found  = 1'b1;
            winner = ID_W'(arb_idx);
         end
      end
      if (32'(winner) == NUM_REQ - 1) ptr_d = '0;
      else                            ptr_d = winner + 1'b1;
   end

   always_comb begin
      data_sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (32'(winner) == k) data_sel = req_data[k*WIDTH +: WIDTH];
      end
   end

   assign window = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
   assign accept = window && found && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:  if (accept) state_d = LOAD;
         LOAD: begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) state_d = accept ? LOAD : IDLE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ser_load_q <= 1'b0;
         ser_data_q <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         words_q    <= '0;
         ptr_q      <= '0;
      end else begin
         ser_load_q <= accept;
         busy_q     <= (state_d != IDLE);
         if (accept) begin
            ser_data_q <= data_sel;
            grant_q    <= winner;
            words_q    <= words_q + 1'b1;
            ptr_q      <= ptr_d;
         end
      end
   end

   assign ser_load   = ser_load_q;
   assign ser_data   = ser_data_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_serializer_scheduler.sv
// Bench for serializer_scheduler: a timer-based reference model checked every cycle,
// plus directed scenarios with literal expectations on a GAP=0 and a GAP=2/CNT_W=4 instance.
module tb_serializer_scheduler;

   localparam int W = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  vld_a, vld_b, rdy_a, rdy_b;
   logic [29:0] dat_a, dat_b;
   logic        load_a, load_b, busy_a, busy_b;
   logic [9:0]  sd_a, sd_b;
   logic [1:0]  gid_a, gid_b;
   logic [15:0] ws_a;
   logic [3:0]  ws_b;

   serializer_scheduler #(.WIDTH(10), .NUM_REQ(3), .GAP(0), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .req_valid(vld_a), .req_data(dat_a), .req_ready(rdy_a),
      .ser_load(load_a), .ser_data(sd_a), .grant_id(gid_a), .busy(busy_a), .words_sent(ws_a));

   serializer_scheduler #(.WIDTH(10), .NUM_REQ(3), .GAP(2), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .req_valid(vld_b), .req_data(dat_b), .req_ready(rdy_b),
      .ser_load(load_b), .ser_data(sd_b), .grant_id(gid_b), .busy(busy_b), .words_sent(ws_b));

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word occupies WIDTH+GAP cycles from its load; the accept window
   // is open when nothing is in flight or on that word's final cycle.
   int         m_remain[2] = '{0, 0};
   int         m_ptr[2]    = '{0, 0};
   int         m_grant[2]  = '{0, 0};
   int         m_words[2]  = '{0, 0};
   bit         m_load[2]   = '{0, 0};
   logic [9:0] m_data[2]   = '{10'd0, 10'd0};

   function automatic int gap_of(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int mask_of(int d);
      return (d == 0) ? 32'hFFFF : 32'hF;
   endfunction

   function automatic logic [2:0] vin(int d);
      return (d == 0) ? vld_a : vld_b;
   endfunction

   function automatic logic [9:0] din(int d, int i);
      logic [29:0] x;
      x = (d == 0) ? dat_a : dat_b;
      return x[i*10 +: 10];
   endfunction

   function automatic int pick(int d);
      logic [2:0] v;
      int i;
      v = vin(d);
      for (int k = 0; k < 3; k++) begin
         i = (m_ptr[d] + k) % 3;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_ready(int d);
      int w;
      if (reset || m_remain[d] > 1) return 3'b000;
      w = pick(d);
      if (w < 0) return 3'b000;
      return 3'(1 << w);
   endfunction

   always @(posedge clk) begin
      int w;
      for (int d = 0; d < 2; d++) begin
         w = (reset || m_remain[d] > 1) ? -1 : pick(d);
         if (reset) begin
            m_remain[d] = 0; m_ptr[d] = 0; m_grant[d] = 0;
            m_words[d] = 0; m_load[d] = 1'b0; m_data[d] = '0;
         end else begin
            m_load[d] = (w >= 0);
            if (w >= 0) begin
               m_data[d]   = din(d, w);
               m_grant[d]  = w;
               m_words[d]  = (m_words[d] + 1) & mask_of(d);
               m_ptr[d]    = (w + 1) % 3;
               m_remain[d] = W + gap_of(d);
            end else if (m_remain[d] > 0) begin
               m_remain[d] = m_remain[d] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("A.req_ready",  32'(rdy_a),  32'(exp_ready(0)));
         check("A.ser_load",   32'(load_a), 32'(m_load[0]));
         check("A.ser_data",   32'(sd_a),   32'(m_data[0]));
         check("A.grant_id",   32'(gid_a),  32'(m_grant[0]));
         check("A.busy",       32'(busy_a), 32'(m_remain[0] > 0));
         check("A.words_sent", 32'(ws_a),   32'(m_words[0]));
         check("B.req_ready",  32'(rdy_b),  32'(exp_ready(1)));
         check("B.ser_load",   32'(load_b), 32'(m_load[1]));
         check("B.ser_data",   32'(sd_b),   32'(m_data[1]));
         check("B.grant_id",   32'(gid_b),  32'(m_grant[1]));
         check("B.busy",       32'(busy_b), 32'(m_remain[1] > 0));
         check("B.words_sent", 32'(ws_b),   32'(m_words[1]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d);
      for (int c = 0; c < 40 && ((d == 0) ? busy_a : busy_b); c++) step();
      check((d == 0) ? "A reaches idle" : "B reaches idle", 32'((d == 0) ? busy_a : busy_b), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads;
      int n;
      int gseq[5];
      logic [9:0] dseq[5];
      int tseq[5];
      int gexp[5];
      logic [9:0] dexp[5];
      int tlast;
      bit seen;

      gexp = '{0, 1, 2, 0, 1};
      dexp = '{10'h111, 10'h222, 10'h333, 10'h111, 10'h222};

      // Reset with a valid present: ready must stay low
      reset = 1'b1; vld_a = 3'b001; vld_b = 3'b000; dat_a = '0; dat_b = '0;
      #1;
      check("t1 ready during reset", 32'(rdy_a), 32'd0);
      step();
      reset = 1'b0; vld_a = 3'b000; chk_en = 1'b1;
      check("t1 ser_load", 32'(load_a), 32'd0);
      check("t1 ser_data", 32'(sd_a), 32'd0);
      check("t1 grant_id", 32'(gid_a), 32'd0);
      check("t1 busy", 32'(busy_a), 32'd0);
      check("t1 words_sent", 32'(ws_a), 32'd0);
      loads = 0;
      repeat (20) begin step(); if (load_a) loads++; end
      check("t1 no load while idle", 32'(loads), 32'd0);

      // Single word from requester 0
      dat_a[9:0] = 10'b1010110001; vld_a = 3'b001;
      #1;
      check("t2 ready", 32'(rdy_a), 32'b001);
      step();
      vld_a = 3'b000;
      check("t2 ser_load", 32'(load_a), 32'd1);
      check("t2 ser_data", 32'(sd_a), 32'b1010110001);
      check("t2 grant_id", 32'(gid_a), 32'd0);
      check("t2 words_sent", 32'(ws_a), 32'd1);
      repeat (9) step();
      check("t2 busy at T+10", 32'(busy_a), 32'd1);
      step();
      check("t2 busy at T+11", 32'(busy_a), 32'd0);

      // Re-reset so the pointer starts at 0
      reset = 1'b1; step(); reset = 1'b0;

      // All three requesters continuously valid
      dat_a = {10'h333, 10'h222, 10'h111}; vld_a = 3'b111;
      n = 0;
      for (int c = 0; c < 80 && n < 5; c++) begin
         step();
         if (load_a) begin
            gseq[n] = gid_a; dseq[n] = sd_a; tseq[n] = cyc; n++;
            if (n == 5) vld_a = 3'b000;
         end
      end
      check("t3 load count", 32'(n), 32'd5);
      for (int i = 0; i < n; i++) begin
         check("t3 grant order", 32'(gseq[i]), 32'(gexp[i]));
         check("t3 word", 32'(dseq[i]), 32'(dexp[i]));
         if (i > 0) check("t3 spacing", 32'(tseq[i] - tseq[i-1]), 32'd10);
      end
      wait_idle(0);

      // Move ptr from 2 to 1 with a single requester-0 word
      vld_a = 3'b001; step(); vld_a = 3'b000;
      check("t4 setup grant", 32'(gid_a), 32'd0);
      wait_idle(0);

      // req0 and req2 valid with ptr=1
      dat_a = {10'h2AA, 10'h000, 10'h155}; vld_a = 3'b101;
      #1;
      check("t4 ready picks 2", 32'(rdy_a), 32'b100);
      step();
      check("t4 first grant", 32'(gid_a), 32'd2);
      check("t4 first word", 32'(sd_a), 32'h2AA);
      seen = 1'b0;
      for (int c = 0; c < 15 && !seen; c++) begin
         step();
         if (load_a) seen = 1'b1;
      end
      vld_a = 3'b000;
      check("t4 second load seen", 32'(seen), 32'd1);
      check("t4 second grant", 32'(gid_a), 32'd0);
      check("t4 second word", 32'(sd_a), 32'h155);
      wait_idle(0);

      // Reset in the middle of a word
      dat_a[9:0] = 10'b1010100101; vld_a = 3'b001;
      step();
      vld_a = 3'b000;
      check("t5 load", 32'(load_a), 32'd1);
      check("t5 word", 32'(sd_a), 32'b1010100101);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5 busy after reset", 32'(busy_a), 32'd0);
      check("t5 load after reset", 32'(load_a), 32'd0);
      loads = 0;
      repeat (15) begin step(); if (load_a) loads++; end
      check("t5 no load after reset", 32'(loads), 32'd0);
      vld_a = 3'b111;
      #1;
      check("t5 ptr back at 0", 32'(rdy_a), 32'b001);
      step();
      vld_a = 3'b000;
      check("t5 new grant", 32'(gid_a), 32'd0);
      wait_idle(0);

      // GAP=2 spacing and 4-bit counter wrap on the second instance
      dat_b[19:10] = 10'h155; vld_b = 3'b010;
      n = 0; tlast = 0;
      for (int c = 0; c < 300 && n < 17; c++) begin
         step();
         if (load_b) begin
            if (n > 0) check("t6 spacing GAP=2", 32'(cyc - tlast), 32'd12);
            tlast = cyc; n++;
            if (n == 17) vld_b = 3'b000;
         end
      end
      check("t6 load count", 32'(n), 32'd17);
      check("t7 words_sent wrapped", 32'(ws_b), 32'd1);
      check("t6 grant", 32'(gid_b), 32'd1);
      wait_idle(1);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
